// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns the slave response on a single-cycle strobe. PREADY wait states
// are bounded by a programmable timeout so a hung slave cannot stall callers.
module apb_master #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    // command side
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    // response side
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    // APB side
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic          PREADY,
    input  logic [DW-1:0] PRDATA,
    input  logic          PSLVERR
);

    // Counter needs at least one bit even when the timeout is disabled.
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CntLast = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CW-1:0] CntMax  = {CW{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;
    logic          rsp_timeout_q;

    logic accept;
    logic timeout_hit;

    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && !PREADY && (cnt_q == CntLast);

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (PREADY || timeout_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State-decoded outputs; ready is also held low while reset is asserted
    always_comb begin
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        unique case (state_q)
            StIdle:   cmd_ready = !PRESET;
            StSetup:  PSEL = 1'b1;
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture, wait counter and response capture
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q         <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;

            // Address/data only move on acceptance so they stay stable all transfer
            if (accept) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
            end

            if (state_q == StSetup) begin
                cnt_q <= '0;
            end else if (state_q == StAccess && cnt_q != CntMax) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (state_q == StAccess) begin
                if (PREADY) begin
                    rsp_valid_q   <= 1'b1;
                    rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                    rsp_err_q     <= PSLVERR;
                    rsp_timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_q   <= 1'b1;
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers checked
// against a transfer-level model (ACCESS length, response fields).
module tb_apb_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          PCLK;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour knobs: PREADY rises in ACCESS cycle number sl_waits
    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = '0;
    int          acc_cnt;

    apb_master #(
        .DW          (DW),
        .AW          (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    assign PREADY  = PSEL && PENABLE && (acc_cnt == sl_waits);
    assign PRDATA  = sl_rdata;
    assign PSLVERR = sl_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".cmd_ready"}, cmd_ready, 0);
        check_eq({tag, ".psel"}, PSEL, 0);
        check_eq({tag, ".penable"}, PENABLE, 0);
        check_eq({tag, ".pwrite"}, PWRITE, 0);
        check_eq({tag, ".paddr"}, PADDR, 0);
        check_eq({tag, ".pwdata"}, PWDATA, 0);
        check_eq({tag, ".rsp_valid"}, rsp_valid, 0);
        check_eq({tag, ".rsp_rdata"}, rsp_rdata, 0);
        check_eq({tag, ".rsp_err"}, rsp_err, 0);
        check_eq({tag, ".rsp_timeout"}, rsp_timeout, 0);
    endtask

    // Entered and left just after a falling edge.
    task automatic do_xfer(input string tag, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int w, input bit e,
                           input logic [31:0] rd);
        bit          to;
        int          n_acc;
        int          k;
        logic [31:0] exp_rd;
        to     = (w >= int'(TO));
        n_acc  = to ? int'(TO) : w + 1;
        exp_rd = (to || wr) ? 32'h0 : rd;
        sl_waits = w;
        sl_err   = e;
        sl_rdata = rd;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        check_eq({tag, ".ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(posedge PCLK);
        #1;
        // Junk on the command bus must not reach the APB side mid-transfer
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
        @(negedge PCLK);
        check_eq({tag, ".setup_psel"}, PSEL, 1);
        check_eq({tag, ".setup_pen"}, PENABLE, 0);
        check_eq({tag, ".setup_paddr"}, PADDR, a);
        check_eq({tag, ".setup_pwrite"}, PWRITE, wr);
        check_eq({tag, ".setup_pwdata"}, PWDATA, wd);
        check_eq({tag, ".setup_ready"}, cmd_ready, 0);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge PCLK);
            check_eq({tag, ".acc_psel"}, PSEL, 1);
            check_eq({tag, ".acc_pen"}, PENABLE, 1);
            check_eq({tag, ".acc_paddr"}, PADDR, a);
            check_eq({tag, ".acc_pwdata"}, PWDATA, wd);
            check_eq({tag, ".acc_rspv"}, rsp_valid, 0);
        end
        @(negedge PCLK);
        check_eq({tag, ".rsp_valid"}, rsp_valid, 1);
        check_eq({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
        check_eq({tag, ".rsp_err"}, rsp_err, to ? 1'b1 : e);
        check_eq({tag, ".rsp_timeout"}, rsp_timeout, to);
        check_eq({tag, ".end_psel"}, PSEL, 0);
        check_eq({tag, ".end_ready"}, cmd_ready, 1);
        check_eq({tag, ".hold_paddr"}, PADDR, a);
        @(negedge PCLK);
        check_eq({tag, ".rsp_drop"}, rsp_valid, 0);
        check_eq({tag, ".rdata_hold"}, rsp_rdata, exp_rd);
        check_eq({tag, ".to_hold"}, rsp_timeout, to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check_all_zero("por");
        PRESET = 1'b0;
        @(negedge PCLK);
        check_eq("por.ready_after", cmd_ready, 1);

        // Plan scenarios
        do_xfer("wr0", 1'b1, 32'h0, 32'd10, 0, 1'b0, 32'hDEAD_BEEF);
        do_xfer("rdwait", 1'b0, 32'h8, 32'h0, 3, 1'b0, 32'hA5A5_0008);
        do_xfer("slverr", 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h1234_5678);
        do_xfer("tmo", 1'b0, 32'h10, 32'h0, 99, 1'b1, 32'hFFFF_FFFF);
        do_xfer("post_tmo", 1'b0, 32'h14, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
        do_xfer("tmo_edge", 1'b1, 32'h18, 32'h77, 3, 1'b0, 32'h0);

        // Back-to-back writes with cmd_valid held high
        sl_waits  = 0;
        sl_err    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h4;
        cmd_wdata = 32'd1;
        @(posedge PCLK);
        #1;
        cmd_addr  = 32'hC;
        cmd_wdata = 32'd2;
        for (int off = 1; off <= 7; off++) begin
            @(negedge PCLK);
            check_eq("b2b.rsp_valid", rsp_valid, (off == 3 || off == 6));
            check_eq("b2b.psel", PSEL, (off == 1 || off == 2 || off == 4 || off == 5));
            check_eq("b2b.penable", PENABLE, (off == 2 || off == 5));
            check_eq("b2b.paddr", PADDR, (off <= 3) ? 32'h4 : 32'hC);
            check_eq("b2b.pwdata", PWDATA, (off <= 3) ? 32'd1 : 32'd2);
            if (off == 3) begin
                check_eq("b2b.ready", cmd_ready, 1);
                @(posedge PCLK);
                #1;
                cmd_valid = 1'b0;
            end
        end

        // Reset in the middle of a stalled ACCESS
        sl_waits  = 99;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h55;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check_eq("rst.in_access", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check_all_zero("rst1");
        @(negedge PCLK);
        check_all_zero("rst2");
        PRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            check_eq("rst.no_rsp", rsp_valid, 0);
            check_eq("rst.ready", cmd_ready, 1);
            check_eq("rst.psel", PSEL, 0);
        end

        // Randomized transfers against the transfer-level model
        for (int n = 0; n < 24; n++) begin
            do_xfer("rnd", 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
                    1'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
